if_fetch_unit: RTL and testbench

Instruction-fetch memory engine directly downstream of the PC stage. Accepts one fetch request (PC) at a time and reads four consecutive bytes over the shared 8-bit memory port through the memory arbiter. Assembles the bytes little-endian into a 32-bit instruction and presents it to the IF/ID register with a valid/stall handshake. Back-pressures the PC stage via `busy_o` and discards in-flight work on a jump flush.

---
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Fetches one 32-bit instruction as four little-endian byte reads; 6 cycles request-to-valid with continuous grant.
// Ungranted cycles hold the read and add one cycle each; id_stall_i holds the result; busy_o back-pressures the PC stage.
module if_fetch_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] req_pc_i,
    output logic        busy_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        id_stall_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           inst_q, inst_d;
    logic [2:0]            iss_cnt_q, iss_cnt_d;
    logic [2:0]            rcv_cnt_q, rcv_cnt_d;
    logic [RD_LATENCY-1:0] pend_q, pend_d;
    logic                  issue_fire;
    logic                  rcv_fire;

    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = (state_q == READ) && (iss_cnt_q < 3'd4);
    assign mem_addr_o   = pc_q + {29'd0, iss_cnt_q};
    assign issue_fire   = mem_req_o && mem_grant_i;
    // Receive is gated by READ so a stale byte can never land outside a fetch.
    assign rcv_fire     = (state_q == READ) && pend_q[RD_LATENCY-1];
    assign inst_valid_o = (state_q == DONE);
    assign inst_o       = inst_valid_o ? inst_q : 32'd0;
    assign inst_pc_o    = inst_valid_o ? pc_q   : 32'd0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        iss_cnt_d = iss_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        // One bit per outstanding read cycle; the oldest bit marks the byte arriving now.
        pend_d    = pend_q << 1;
        pend_d[0] = issue_fire;

        if (flush_i) begin
            state_d   = IDLE;
            iss_cnt_d = 3'd0;
            rcv_cnt_d = 3'd0;
            pend_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        pc_d      = req_pc_i;
                        iss_cnt_d = 3'd0;
                        rcv_cnt_d = 3'd0;
                        state_d   = READ;
                    end
                end
                READ: begin
                    if (issue_fire) begin
                        iss_cnt_d = iss_cnt_q + 3'd1;
                    end
                    if (rcv_fire) begin
                        inst_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_din_i;
                        rcv_cnt_d = rcv_cnt_q + 3'd1;
                        if (rcv_cnt_q == 3'd3) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!id_stall_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= 32'd0;
            inst_q    <= 32'd0;
            iss_cnt_q <= 3'd0;
            rcv_cnt_q <= 3'd0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, basic fetch, grant gaps, stall, wrap, flush and reset mid-fetch.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] req_pc_i;
    logic        busy_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        id_stall_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RD_LATENCY(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .req_pc_i     (req_pc_i),
        .busy_o       (busy_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_grant_i  (mem_grant_i),
        .mem_din_i    (mem_din_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .id_stall_i   (id_stall_i)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0102: return 8'h10;
            32'h0000_0103: return 8'h00;
            32'h0000_0200: return 8'h93;
            32'h0000_0201: return 8'h00;
            32'h0000_0202: return 8'h40;
            32'h0000_0203: return 8'h06;
            32'hFFFF_FFFE: return 8'hB7;
            32'hFFFF_FFFF: return 8'h02;
            32'h0000_0000: return 8'h00;
            32'h0000_0001: return 8'h80;
            default:       return 8'hEE;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the memory answers a granted read one cycle later.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        fire = mem_req_o && mem_grant_i;
        addr = mem_addr_o;
        @(posedge clk);
        #1;
        mem_din_i = fire ? mem_byte(addr) : 8'hEE;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},  {31'd0, busy_o},       32'd0);
        chk({tag, " mreq"},  {31'd0, mem_req_o},    32'd0);
        chk({tag, " valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({tag, " inst"},  inst_o,                32'd0);
        chk({tag, " pc"},    inst_pc_o,             32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_i       = 1'b1;
        req_pc_i    = 32'h100;
        flush_i     = 1'b0;
        mem_grant_i = 1'b1;
        id_stall_i  = 1'b0;
        mem_din_i   = 8'h00;

        tick();
        tick();
        chk_idle("reset");
        chk("reset addr", mem_addr_o, 32'd0);

        // Basic fetch: this cycle is T.
        rst = 1'b0;
        tick();
        req_i = 1'b0;
        chk("basic busy T+1", {31'd0, busy_o}, 32'd1);
        chk("basic mreq T+1", {31'd0, mem_req_o}, 32'd1);
        chk("basic addr T+1", mem_addr_o, 32'h100);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("basic addr", mem_addr_o, 32'h100 + i);
        end
        tick();
        chk("basic mreq T+5", {31'd0, mem_req_o}, 32'd0);
        chk("basic valid T+5", {31'd0, inst_valid_o}, 32'd0);
        tick();
        chk("basic valid T+6", {31'd0, inst_valid_o}, 32'd1);
        chk("basic inst T+6", inst_o, 32'h0010_0513);
        chk("basic pc T+6", inst_pc_o, 32'h100);
        tick();
        chk_idle("basic T+7");

        // Grant withheld at T+2 and T+3.
        req_i = 1'b1;
        req_pc_i = 32'h100;
        tick();
        req_i = 1'b0;
        chk("gap addr T+1", mem_addr_o, 32'h100);
        tick();
        mem_grant_i = 1'b0;
        chk("gap addr T+2", mem_addr_o, 32'h101);
        tick();
        chk("gap mreq T+3", {31'd0, mem_req_o}, 32'd1);
        chk("gap addr T+3", mem_addr_o, 32'h101);
        tick();
        mem_grant_i = 1'b1;
        chk("gap addr T+4", mem_addr_o, 32'h101);
        tick();
        chk("gap addr T+5", mem_addr_o, 32'h102);
        tick();
        chk("gap addr T+6", mem_addr_o, 32'h103);
        tick();
        chk("gap valid T+7", {31'd0, inst_valid_o}, 32'd0);
        tick();
        chk("gap valid T+8", {31'd0, inst_valid_o}, 32'd1);
        chk("gap inst T+8", inst_o, 32'h0010_0513);
        tick();
        chk("gap busy T+9", {31'd0, busy_o}, 32'd0);

        // Wrapping address, then 3 stall cycles in DONE.
        req_i = 1'b1;
        req_pc_i = 32'hFFFF_FFFE;
        id_stall_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("wrap addr 0", mem_addr_o, 32'hFFFF_FFFE);
        tick();
        chk("wrap addr 1", mem_addr_o, 32'hFFFF_FFFF);
        tick();
        chk("wrap addr 2", mem_addr_o, 32'h0000_0000);
        tick();
        chk("wrap addr 3", mem_addr_o, 32'h0000_0001);
        tick();
        tick();
        chk("stall valid T+6", {31'd0, inst_valid_o}, 32'd1);
        chk("stall inst T+6", inst_o, 32'h8000_02B7);
        chk("stall pc T+6", inst_pc_o, 32'hFFFF_FFFE);
        // Request raised while busy must be ignored.
        req_i = 1'b1;
        req_pc_i = 32'h300;
        tick();
        chk("stall inst T+7", inst_o, 32'h8000_02B7);
        tick();
        chk("stall inst T+8", inst_o, 32'h8000_02B7);
        tick();
        id_stall_i = 1'b0;
        chk("stall valid T+9", {31'd0, inst_valid_o}, 32'd1);
        chk("stall inst T+9", inst_o, 32'h8000_02B7);
        chk("stall pc T+9", inst_pc_o, 32'hFFFF_FFFE);
        tick();
        chk("stall busy T+10", {31'd0, busy_o}, 32'd0);
        chk("stall valid T+10", {31'd0, inst_valid_o}, 32'd0);

        // Held request for 0x300 is accepted now; flush it at T+3.
        tick();
        req_i = 1'b0;
        chk("flush busy T+1", {31'd0, busy_o}, 32'd1);
        chk("flush addr T+1", mem_addr_o, 32'h300);
        tick();
        chk("flush addr T+2", mem_addr_o, 32'h301);
        tick();
        flush_i = 1'b1;
        chk("flush addr T+3", mem_addr_o, 32'h302);
        tick();
        flush_i = 1'b0;
        chk_idle("flush T+4");
        req_i = 1'b1;
        req_pc_i = 32'h200;
        tick();
        req_i = 1'b0;
        chk("refetch addr 0", mem_addr_o, 32'h200);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("refetch addr", mem_addr_o, 32'h200 + i);
        end
        tick();
        tick();
        chk("refetch valid", {31'd0, inst_valid_o}, 32'd1);
        chk("refetch inst", inst_o, 32'h0640_0093);
        chk("refetch pc", inst_pc_o, 32'h200);

        // Flush beats a stalled DONE, then beats a request in IDLE.
        flush_i = 1'b1;
        id_stall_i = 1'b1;
        tick();
        chk_idle("flush DONE");
        req_i = 1'b1;
        req_pc_i = 32'h100;
        tick();
        chk("flush vs req busy", {31'd0, busy_o}, 32'd0);
        chk("flush vs req mreq", {31'd0, mem_req_o}, 32'd0);

        // Reset in the middle of a fetch.
        flush_i = 1'b0;
        id_stall_i = 1'b0;
        tick();
        req_i = 1'b0;
        chk("rstmid busy T+1", {31'd0, busy_o}, 32'd1);
        tick();
        chk("rstmid addr T+2", mem_addr_o, 32'h101);
        rst = 1'b1;
        tick();
        chk_idle("rstmid in reset");
        chk("rstmid addr", mem_addr_o, 32'd0);
        rst = 1'b0;
        tick();
        chk_idle("rstmid after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
